balance_seq: RTL

BALANCE_SEQ -- requirements
Module: balance_seq

---
 rtl/balance_pkg.sv | 32 +++
 rtl/balance_seq_rider_debounce.sv | 49 ++++
 rtl/balance_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/balance_pkg.sv
// Shared types and constants for the balance sequencer: FSM state encoding,
// soft-start full-scale value, motor command width and the ramp scaling helper.
package balance_pkg;

  localparam int MCMD_W = 12;
  localparam int PROD_W = MCMD_W + 9;  // signed command x signed {0, ss_tmr}

  localparam logic [7:0] SS_FULL = 8'hFF;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_ARMED = 3'd1,
    ST_RAMP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } bal_state_t;

  // States in which the motor is driven.
  function automatic logic is_active(bal_state_t s);
    return (s == ST_RAMP) || (s == ST_RUN);
  endfunction

  // Soft-start scaling: (pid * ss) >>> 8 on the full-width signed product,
  // then truncated back to the command width.
  function automatic logic [MCMD_W-1:0] ramp_scale(logic signed [MCMD_W-1:0] pid,
                                                   logic [7:0] ss);
    logic signed [PROD_W-1:0] prod;
    prod = PROD_W'(pid) * PROD_W'($signed({1'b0, ss}));
    return MCMD_W'(prod >>> 8);
  endfunction

endpackage

// File: rtl/balance_seq_rider_debounce.sv
// Rider detect debouncer: the flag toggles only after DEBOUNCE_SMPLS
// consecutive strobed samples disagreeing with it; din is ignored between strobes.
module rider_debounce #(
  parameter int DEBOUNCE_SMPLS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic smp,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (DEBOUNCE_SMPLS < 2) ? 1 : $clog2(DEBOUNCE_SMPLS + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;

  // Count disagreeing samples; a matching sample restarts the run.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (smp) begin
      if (din == flag_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_SMPLS - 1)) begin
        cnt_d  = '0;
        flag_d = din;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign dout = flag_q;

endmodule

// File: rtl/balance_seq.sv
// Balance sequencer: power/rider/soft-start/fault FSM with registered
// controller controls and a scaled motor command.
// Optional watchdog compiled in with macro BALANCE_SEQ_WDOG_EN.
module balance_seq
  import balance_pkg::*;
#(
  parameter int DEBOUNCE_SMPLS = 4,
  parameter int WDOG_CYCLES    = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pwr_btn,
  input  logic                     rider_present,
  input  logic                     ptch_vld,
  input  logic                     tilt_fault,
  input  logic                     batt_low,
  input  logic signed [MCMD_W-1:0] PID_cntrl,
  input  logic        [7:0]        ss_tmr,
  output logic                     pwr_up,
  output logic                     rider_off,
  output logic                     pid_vld,
  output logic signed [MCMD_W-1:0] motor_cmd,
  output logic                     motor_en,
  output logic        [2:0]        state
);

  bal_state_t               state_q, state_d;
  logic                     btn_q;
  logic                     rider_flag, rider_prev_q;
  logic                     pwr_up_q, pwr_up_d;
  logic                     rider_off_q, rider_off_d;
  logic                     motor_en_q, motor_en_d;
  logic                     pid_vld_q, pid_vld_d;
  logic signed [MCMD_W-1:0] motor_cmd_q, motor_cmd_d;
  logic                     press, rider_rise, rider_fall, fault_req, wdog_trip;

  rider_debounce #(.DEBOUNCE_SMPLS(DEBOUNCE_SMPLS)) u_rider_debounce (
    .clk  (clk),
    .rst  (rst),
    .smp  (ptch_vld),
    .din  (rider_present),
    .dout (rider_flag)
  );

`ifdef BALANCE_SEQ_WDOG_EN
  logic [15:0] wdog_q, wdog_d;

  // Cycles since the last strobe while balancing; saturates instead of wrapping.
  always_comb begin
    wdog_d = wdog_q;
    if (!is_active(state_q) || ptch_vld) begin
      wdog_d = '0;
    end else if (wdog_q != 16'hFFFF) begin
      wdog_d = wdog_q + 16'd1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end

  assign wdog_trip = is_active(state_q) && (wdog_q >= 16'(WDOG_CYCLES));
`else
  assign wdog_trip = 1'b0;
`endif

  // Next state (fault > rider > button) and the output values that go with it.
  always_comb begin
    press      = pwr_btn & ~btn_q;
    rider_rise = rider_flag & ~rider_prev_q;
    rider_fall = ~rider_flag & rider_prev_q;
    fault_req  = tilt_fault | batt_low | wdog_trip;

    state_d = state_q;
    case (state_q)
      ST_OFF:   if (press) state_d = ST_ARMED;
      ST_ARMED: begin
        if (rider_rise) state_d = ST_RAMP;
        else if (press) state_d = ST_OFF;
      end
      ST_RAMP, ST_RUN: begin
        if (fault_req)                                    state_d = ST_FAULT;
        else if (rider_fall)                              state_d = ST_ARMED;
        else if (state_q == ST_RAMP && ss_tmr == SS_FULL) state_d = ST_RUN;
      end
      ST_FAULT: if (press) state_d = ST_OFF;
      default:  state_d = ST_OFF;
    endcase

    // Outputs are registered from the next state so they change with state.
    pwr_up_d    = (state_d == ST_ARMED) || is_active(state_d);
    motor_en_d  = is_active(state_d);
    rider_off_d = ~motor_en_d;
    pid_vld_d   = ptch_vld & pwr_up_d;

    // PID_cntrl is valid the cycle after pid_vld; otherwise the command holds.
    motor_cmd_d = motor_cmd_q;
    if (!motor_en_d) begin
      motor_cmd_d = '0;
    end else if (pid_vld_q) begin
      motor_cmd_d = (state_q == ST_RUN) ? PID_cntrl : ramp_scale(PID_cntrl, ss_tmr);
    end
  end

  // FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      btn_q        <= 1'b0;
      rider_prev_q <= 1'b0;
      pwr_up_q     <= 1'b0;
      rider_off_q  <= 1'b1;
      motor_en_q   <= 1'b0;
      pid_vld_q    <= 1'b0;
      motor_cmd_q  <= '0;
    end else begin
      state_q      <= state_d;
      btn_q        <= pwr_btn;
      rider_prev_q <= rider_flag;
      pwr_up_q     <= pwr_up_d;
      rider_off_q  <= rider_off_d;
      motor_en_q   <= motor_en_d;
      pid_vld_q    <= pid_vld_d;
      motor_cmd_q  <= motor_cmd_d;
    end
  end

  assign state     = state_q;
  assign pwr_up    = pwr_up_q;
  assign rider_off = rider_off_q;
  assign pid_vld   = pid_vld_q;
  assign motor_cmd = motor_cmd_q;
  assign motor_en  = motor_en_q;

endmodule
